// File: rtl/arch_reg_status.sv
// -----------------------------------------------------------------------------
// arch_reg_status
//   Architectural register file plus rename/status table. It sits after the
//   reorder buffer (ROB) and in front of the reservation stations.
//   - The ROB commit stream writes the architectural registers. It clears the
//     busy bit when the committing tag is still the newest producer.
//   - A mispredict flush clears every busy bit.
//   - Dispatch renames the destination to the ROB tag allocated that cycle.
//   - Source operands are resolved from the ARF, the ROB read ports, the two
//     CDBs or the commit bypass. They are registered as {ready, tag, data}.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   stall                 dispatch stall: no rename, operand registers hold
//   mispred               ROB flush (same cycle as the branch commit)
//   dec_valid             decoder presents an instruction
//   dec_rs1/dec_rs2       source register indices
//   dec_rd/dec_rd_we      destination index and its write enable
//   dec_tag               ROB tag allocated this cycle
//   rob_tag1/rob_tag2     tags sent to the ROB read ports (combinational)
//   rob_data1/rob_data2   {valid, data} from the ROB, same cycle
//   cdb1/cdb2             {tag, data} result buses; tag 0 means idle
//   commit_we/dest/tag/data  ROB commit stream
//   op1/op2               registered {ready, tag, data} operand packets
//   op_valid              op1/op2 belong to a dispatched instruction
// -----------------------------------------------------------------------------
module arch_reg_status #(
   parameter int NREG = 64,
   parameter int DW   = 32,
   parameter int TW   = 6,
   parameter int IW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                mispred,
   input  logic                dec_valid,
   input  logic [IW-1:0]       dec_rs1,
   input  logic [IW-1:0]       dec_rs2,
   input  logic [IW-1:0]       dec_rd,
   input  logic                dec_rd_we,
   input  logic [TW-1:0]       dec_tag,
   output logic [TW-1:0]       rob_tag1,
   output logic [TW-1:0]       rob_tag2,
   input  logic [DW:0]         rob_data1,
   input  logic [DW:0]         rob_data2,
   input  logic [TW+DW-1:0]    cdb1,
   input  logic [TW+DW-1:0]    cdb2,
   input  logic                commit_we,
   input  logic [IW-1:0]       commit_dest,
   input  logic [TW-1:0]       commit_tag,
   input  logic [DW-1:0]       commit_data,
   output logic [TW+DW:0]      op1,
   output logic [TW+DW:0]      op2,
   output logic                op_valid
);

   localparam int OW = TW + DW + 1;

   logic [DW-1:0] regs_q [NREG];
   logic          busy_q [NREG];
   logic [TW-1:0] tag_q  [NREG];

   logic [TW-1:0] cdb1_tag, cdb2_tag;
   logic [DW-1:0] cdb1_data, cdb2_data;
   logic [OW-1:0] look1, look2;
   logic          rename;

   assign cdb1_tag  = cdb1[TW+DW-1:DW];
   assign cdb1_data = cdb1[DW-1:0];
   assign cdb2_tag  = cdb2[TW+DW-1:DW];
   assign cdb2_data = cdb2[DW-1:0];

   assign rob_tag1 = tag_q[dec_rs1];
   assign rob_tag2 = tag_q[dec_rs2];

   // Resolves one source against the table as it stood before this cycle's
   // rename. That way an instruction with rs == rd sees the older producer.
   function automatic logic [OW-1:0] lookup(input logic [IW-1:0] rs,
                                            input logic [DW:0]   rob_rd);
      logic [TW-1:0] t;
      t = tag_q[rs];
      if (rs == '0)
         lookup = {1'b1, {TW{1'b0}}, {DW{1'b0}}};
      else if (!busy_q[rs])
         lookup = {1'b1, {TW{1'b0}}, regs_q[rs]};
      else if (rob_rd[DW])
         lookup = {1'b1, t, rob_rd[DW-1:0]};
      // The table never holds tag 0 for a busy register. The non-zero test
      // still keeps an idle CDB from matching.
      else if (cdb1_tag == t && cdb1_tag != '0)
         lookup = {1'b1, t, cdb1_data};
      else if (cdb2_tag == t && cdb2_tag != '0)
         lookup = {1'b1, t, cdb2_data};
      else if (commit_we && commit_tag == t)
         lookup = {1'b1, t, commit_data};
      else
         lookup = {1'b0, t, {DW{1'b0}}};
   endfunction

   always_comb begin
      look1 = lookup(dec_rs1, rob_data1);
      look2 = lookup(dec_rs2, rob_data2);
   end

   assign rename = !stall && !mispred && dec_valid && dec_rd_we && (dec_rd != '0);

   // NOTE: the table is reset in full. The reset value of every register is
   // architecturally visible, so this array cannot be left uninitialised
   // like a plain RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         // The commit write lands even during a flush.
         if (commit_we && commit_dest != '0) begin
            regs_q[commit_dest] <= commit_data;
            if (tag_q[commit_dest] == commit_tag)
               busy_q[commit_dest] <= 1'b0;
         end
         // NOTE: with non-blocking assignments the last assignment in the
         // block wins. The flush and a same-edge rename are placed after the
         // commit clear so that they override it.
         if (mispred) begin
            for (int i = 0; i < NREG; i++)
               busy_q[i] <= 1'b0;
         end else if (rename) begin
            busy_q[dec_rd] <= 1'b1;
            tag_q[dec_rd]  <= dec_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op1      <= '0;
         op2      <= '0;
         op_valid <= 1'b0;
      end else if (mispred) begin
         op_valid <= 1'b0;
      end else if (!stall) begin
         op1      <= look1;
         op2      <= look2;
         op_valid <= dec_valid;
      end
   end

endmodule

// File: tb/tb_arch_reg_status.sv
// -----------------------------------------------------------------------------
// tb_arch_reg_status
//   Self-checking bench for arch_reg_status. A behavioural model of the
//   register state (values, busy flags, newest producer tag) and of the ROB
//   contents predicts op1/op2/op_valid after every clock edge and the ROB
//   read tags mid-cycle. Directed scenarios with literal expectations come
//   first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_arch_reg_status;

   logic        clk = 1'b0;
   logic        reset, stall, mispred, dec_valid, dec_rd_we;
   logic [5:0]  dec_rs1, dec_rs2, dec_rd, dec_tag;
   logic [5:0]  rob_tag1, rob_tag2;
   logic [32:0] rob_data1, rob_data2;
   logic [37:0] cdb1, cdb2;
   logic        commit_we;
   logic [5:0]  commit_dest, commit_tag;
   logic [31:0] commit_data;
   logic [38:0] op1, op2;
   logic        op_valid;

   // ROB contents as seen by the read ports.
   logic        rob_v [64];
   logic [31:0] rob_d [64];

   assign rob_data1 = {rob_v[rob_tag1], rob_d[rob_tag1]};
   assign rob_data2 = {rob_v[rob_tag2], rob_d[rob_tag2]};

   always #5 clk = ~clk;

   arch_reg_status dut (
      .clk(clk), .reset(reset), .stall(stall), .mispred(mispred),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_tag(dec_tag),
      .rob_tag1(rob_tag1), .rob_tag2(rob_tag2),
      .rob_data1(rob_data1), .rob_data2(rob_data2),
      .cdb1(cdb1), .cdb2(cdb2),
      .commit_we(commit_we), .commit_dest(commit_dest),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .op1(op1), .op2(op2), .op_valid(op_valid)
   );

   int checks = 0;
   int errors = 0;
   bit checking_on = 0;

   task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_val  [64];
   bit          m_busy [64];
   logic [5:0]  m_prod [64];
   logic [38:0] e_op1 = '0, e_op2 = '0;
   logic        e_valid = 1'b0;

   initial begin
      for (int i = 0; i < 64; i++) begin
         m_val[i] = '0; m_busy[i] = 0; m_prod[i] = '0;
         rob_v[i] = 1'b0; rob_d[i] = '0;
      end
   end

   // Where the current value of register r can be found right now.
   function automatic logic [38:0] model_operand(input logic [5:0] r);
      logic [5:0] p;
      if (r == 0) return {1'b1, 6'd0, 32'd0};
      if (!m_busy[r]) return {1'b1, 6'd0, m_val[r]};
      p = m_prod[r];
      if (rob_v[p])                      return {1'b1, p, rob_d[p]};
      if (cdb1[37:32] == p)              return {1'b1, p, cdb1[31:0]};
      if (cdb2[37:32] == p)              return {1'b1, p, cdb2[31:0]};
      if (commit_we && commit_tag == p)  return {1'b1, p, commit_data};
      return {1'b0, p, 32'd0};
   endfunction

   // Inputs change at posedge+2, so at posedge+1 the bench still sees the
   // values the DUT sampled at that edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checking_on && !reset) begin
            check("rob_tag1", {33'd0, rob_tag1}, {33'd0, m_prod[dec_rs1]});
            check("rob_tag2", {33'd0, rob_tag2}, {33'd0, m_prod[dec_rs2]});
         end
         @(posedge clk);
         #1;
         if (reset) begin
            for (int i = 0; i < 64; i++) begin
               m_val[i] = '0; m_busy[i] = 0; m_prod[i] = '0;
            end
            e_op1 = '0; e_op2 = '0; e_valid = 1'b0;
         end else begin
            if (mispred) e_valid = 1'b0;
            else if (!stall) begin
               e_op1 = model_operand(dec_rs1);
               e_op2 = model_operand(dec_rs2);
               e_valid = dec_valid;
            end
            if (commit_we && commit_dest != 0) begin
               m_val[commit_dest] = commit_data;
               if (m_prod[commit_dest] == commit_tag) m_busy[commit_dest] = 0;
            end
            if (mispred) begin
               for (int i = 0; i < 64; i++) m_busy[i] = 0;
            end else if (!stall && dec_valid && dec_rd_we && dec_rd != 0) begin
               m_busy[dec_rd] = 1;
               m_prod[dec_rd] = dec_tag;
            end
         end
         if (checking_on) begin
            check("op1", op1, e_op1);
            check("op2", op2, e_op2);
            check("op_valid", {38'd0, op_valid}, {38'd0, e_valid});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stall = 0; mispred = 0; dec_valid = 0; dec_rd_we = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_tag = 0;
      cdb1 = '0; cdb2 = '0;
      commit_we = 0; commit_dest = 0; commit_tag = 0; commit_data = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      tick();
      checking_on = 1;
      tick();
      check("reset op1", op1, 39'd0);
      check("reset op_valid", {38'd0, op_valid}, 39'd0);

      // 1: read x5 after reset.
      reset = 0;
      dec_valid = 1; dec_rs1 = 5;
      tick();
      check("t1 op1", op1, {1'b1, 6'd0, 32'd0});
      check("t1 op_valid", {38'd0, op_valid}, 39'd1);

      // 2: rename x3 to tag 7, then read it with the ROB entry not ready.
      dec_rs1 = 0; dec_rd = 3; dec_rd_we = 1; dec_tag = 7;
      tick();
      dec_rd_we = 0; dec_rs1 = 3;
      tick();
      check("t2 op1", op1, {1'b0, 6'd7, 32'd0});

      // 3: the same read with a CDB2 bypass.
      cdb2 = {6'd7, 32'hDEADBEEF};
      tick();
      check("t3 op1", op1, {1'b1, 6'd7, 32'hDEADBEEF});
      cdb2 = '0;

      // 4: commit x3 and read it back from the ARF.
      dec_valid = 0;
      commit_we = 1; commit_dest = 3; commit_tag = 7; commit_data = 55;
      tick();
      commit_we = 0; dec_valid = 1; dec_rs1 = 3;
      tick();
      check("t4 op1", op1, {1'b1, 6'd0, 32'd55});
      // 4b: rename to tag 9, then commit of the stale tag 7 keeps x3 busy.
      dec_valid = 1; dec_rd = 3; dec_rd_we = 1; dec_tag = 9; dec_rs1 = 0;
      tick();
      dec_rd_we = 0; dec_valid = 0;
      commit_we = 1; commit_dest = 3; commit_tag = 7; commit_data = 55;
      tick();
      commit_we = 0; dec_valid = 1; dec_rs1 = 3;
      tick();
      check("t4b op1", op1, {1'b0, 6'd9, 32'd0});
      // 4c: commit tag 9 on the same edge as a rename to tag 10; rename wins.
      commit_we = 1; commit_dest = 3; commit_tag = 9; commit_data = 77;
      dec_rd = 3; dec_rd_we = 1; dec_tag = 10; dec_rs1 = 0;
      tick();
      commit_we = 0; dec_rd_we = 0; dec_rs1 = 3;
      tick();
      check("t4c op1", op1, {1'b0, 6'd10, 32'd0});

      // 5: flush with a commit to x4 and a dispatch of x5 on the same edge.
      mispred = 1; commit_we = 1; commit_dest = 4; commit_tag = 11; commit_data = 32'hAA;
      dec_valid = 1; dec_rd = 5; dec_rd_we = 1; dec_tag = 12; dec_rs1 = 3;
      tick();
      check("t5 flush op_valid", {38'd0, op_valid}, 39'd0);
      mispred = 0; commit_we = 0; dec_rd_we = 0; dec_rs1 = 3; dec_rs2 = 4;
      tick();
      check("t5 x3", op1, {1'b1, 6'd0, 32'd77});
      check("t5 x4", op2, {1'b1, 6'd0, 32'hAA});
      dec_rs1 = 5; dec_rs2 = 0;
      tick();
      check("t5 x5 not renamed", op1, {1'b1, 6'd0, 32'd0});

      // 6: writes to x0 are ignored; stall holds the operand registers.
      dec_rd = 0; dec_rd_we = 1; dec_tag = 13; dec_rs1 = 0;
      commit_we = 1; commit_dest = 0; commit_tag = 13; commit_data = 32'hFF;
      tick();
      check("t6 x0", op1, {1'b1, 6'd0, 32'd0});
      commit_we = 0; dec_rd_we = 0;
      stall = 1; dec_valid = 0; dec_rs1 = 4;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6 stall op1", op1, {1'b1, 6'd0, 32'd0});
         check("t6 stall op_valid", {38'd0, op_valid}, 39'd1);
      end
      stall = 0; dec_valid = 1; dec_rs1 = 0;
      tick();
      check("t6 x0 after", op1, {1'b1, 6'd0, 32'd0});

      // Randomized traffic over a small register and tag space so that
      // renames, bypasses and commits collide often.
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] d;
         stall     = ($urandom_range(0, 7) == 0);
         mispred   = ($urandom_range(0, 40) == 0);
         dec_valid = $urandom_range(0, 1);
         dec_rs1   = 6'($urandom_range(0, 7));
         dec_rs2   = 6'($urandom_range(0, 7));
         dec_rd    = 6'($urandom_range(0, 7));
         dec_rd_we = $urandom_range(0, 1);
         dec_tag   = 6'($urandom_range(1, 15));
         cdb1 = {6'($urandom_range(0, 15)), 32'($urandom)};
         cdb2 = {6'($urandom_range(0, 15)), 32'($urandom)};
         if ($urandom_range(0, 1) == 0) cdb2[37:32] = cdb1[37:32];
         commit_we   = $urandom_range(0, 1);
         d           = 6'($urandom_range(0, 7));
         commit_dest = d;
         commit_tag  = ($urandom_range(0, 2) != 0) ? m_prod[d] : 6'($urandom_range(1, 15));
         commit_data = $urandom;
         for (int k = 1; k < 16; k++) begin
            rob_v[k] = ($urandom_range(0, 3) == 0);
            rob_d[k] = $urandom;
         end
         if ($urandom_range(0, 200) == 0) reset = 1; else reset = 0;
         tick();
      end

      idle();
      reset = 0;
      tick();
      checking_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
